// File: rtl/datapath_pkg.sv
// Shared definitions for the matrix load/store sequencer: load/store encodings,
// the queued op payload and the sequencer state type.
package datapath_pkg;

    // Widest address/stride a queued op can carry; WORD_W of the sequencer must not exceed it.
    localparam int OP_WORD_W = 32;

    localparam logic [1:0] LS_LOAD  = 2'b01;
    localparam logic [1:0] LS_STORE = 2'b10;

    typedef struct packed {
        logic [1:0]           ls;
        logic [3:0]           rd;
        logic [OP_WORD_W-1:0] addr0;
        logic [OP_WORD_W-1:0] stride;
    } matrix_ls_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    function automatic logic ls_is_legal(input logic [1:0] ls);
        return (ls == LS_LOAD) || (ls == LS_STORE);
    endfunction

endpackage

// File: rtl/matrix_ls_seq_if.sv
// Issue-side and scratchpad-side signals of the matrix load/store sequencer.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface matrix_ls_seq_if #(
    parameter int ROWS   = 4,
    parameter int WORD_W = 32
);
    localparam int ROW_W = $clog2(ROWS);

    logic              enable;
    logic [1:0]        ls_in;
    logic [3:0]        rd_in;
    logic [3:0]        rs_in;
    logic [WORD_W-1:0] base_in;
    logic [WORD_W-1:0] stride_in;
    logic [10:0]       imm_in;
    logic              op_ready;
    logic              mhit;
    logic              req_valid;
    logic [1:0]        req_ls;
    logic [WORD_W-1:0] req_addr;
    logic [3:0]        req_mreg;
    logic [ROW_W-1:0]  req_row;
    logic              done;
    logic [3:0]        done_mreg;
    logic              busy;
    logic              illegal;

    modport slave (
        input  enable, ls_in, rd_in, rs_in, base_in, stride_in, imm_in, mhit,
        output op_ready, req_valid, req_ls, req_addr, req_mreg, req_row,
               done, done_mreg, busy, illegal
    );

    modport master (
        output enable, ls_in, rd_in, rs_in, base_in, stride_in, imm_in, mhit,
        input  op_ready, req_valid, req_ls, req_addr, req_mreg, req_row,
               done, done_mreg, busy, illegal
    );

endinterface

// File: rtl/matrix_ls_fifo.sv
// Op queue for the matrix load/store sequencer: QDEPTH entries, head visible
// combinationally, push refused when full and pop ignored when empty.
module matrix_ls_fifo
    import datapath_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          push,
    input  matrix_ls_op_t push_data,
    input  logic          pop,
    output matrix_ls_op_t head,
    output logic          empty,
    output logic          full
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    matrix_ls_op_t mem_q [QDEPTH];

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // QDEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/matrix_ls_seq.sv
// Matrix load/store sequencer: queues accepted ops and issues ROWS row requests
// per op to the scratchpad, one per mhit, then pulses done.
module matrix_ls_seq
    import datapath_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int QDEPTH = 2,
    parameter int WORD_W = 32
) (
    input  logic           CLK,
    input  logic           nRST,
    matrix_ls_seq_if.slave bus
);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    logic              ls_legal;
    logic              accept;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic [WORD_W-1:0] imm_ext;
    matrix_ls_op_t     op_in;
    matrix_ls_op_t     head;
    logic              unused_rs;

    seq_state_e        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] stride_q, stride_d;
    logic [1:0]        ls_q, ls_d;
    logic [3:0]        mreg_q, mreg_d;
    logic              req_valid_q, req_valid_d;
    logic              done_q, done_d;
    logic [3:0]        done_mreg_q, done_mreg_d;
    logic              illegal_q, illegal_d;

    // The base register index is only meaningful to the issue stage.
    assign unused_rs = ^bus.rs_in;

    assign ls_legal  = ls_is_legal(bus.ls_in);
    assign accept    = bus.enable && !fifo_full && ls_legal;
    assign illegal_d = bus.enable && !fifo_full && !ls_legal;
    assign imm_ext   = {{(WORD_W-11){bus.imm_in[10]}}, bus.imm_in};

    always_comb begin
        op_in        = '0;
        op_in.ls     = bus.ls_in;
        op_in.rd     = bus.rd_in;
        op_in.addr0  = OP_WORD_W'(bus.base_in + imm_ext);
        op_in.stride = OP_WORD_W'(bus.stride_in);
    end

    matrix_ls_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .push      (accept),
        .push_data (op_in),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // addr_q is the live row address; each accepted row adds the stride to it.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        ls_d        = ls_q;
        mreg_d      = mreg_q;
        req_valid_d = req_valid_q;
        done_d      = 1'b0;
        done_mreg_d = done_mreg_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    state_d     = ST_ISSUE;
                    row_d       = '0;
                    addr_d      = WORD_W'(head.addr0);
                    stride_d    = WORD_W'(head.stride);
                    ls_d        = head.ls;
                    mreg_d      = head.rd;
                    req_valid_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (bus.mhit) begin
                    if (row_q == LAST_ROW) begin
                        state_d     = ST_DONE;
                        req_valid_d = 1'b0;
                        done_d      = 1'b1;
                        done_mreg_d = mreg_q;
                    end else begin
                        row_d  = row_q + 1'b1;
                        addr_d = addr_q + stride_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            addr_q      <= '0;
            stride_q    <= '0;
            ls_q        <= '0;
            mreg_q      <= '0;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            done_mreg_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            ls_q        <= ls_d;
            mreg_q      <= mreg_d;
            req_valid_q <= req_valid_d;
            done_q      <= done_d;
            done_mreg_q <= done_mreg_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.op_ready  = !fifo_full;
    assign bus.req_valid = req_valid_q;
    assign bus.req_ls    = ls_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_mreg  = mreg_q;
    assign bus.req_row   = row_q;
    assign bus.done      = done_q;
    assign bus.done_mreg = done_mreg_q;
    assign bus.illegal   = illegal_q;
    assign bus.busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_matrix_ls_seq.sv
// Directed bench for matrix_ls_seq: a row/done scoreboard built from plain
// address arithmetic, plus hand-computed timing and value expectations.
module tb_matrix_ls_seq;
    import datapath_pkg::*;

    localparam int ROWS   = 4;
    localparam int QDEPTH = 2;
    localparam int WORD_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    matrix_ls_seq_if #(.ROWS(ROWS), .WORD_W(WORD_W)) bus ();

    matrix_ls_seq #(
        .ROWS   (ROWS),
        .QDEPTH (QDEPTH),
        .WORD_W (WORD_W)
    ) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]        ls;
        logic [3:0]        mreg;
        logic [WORD_W-1:0] addr;
        int                row;
    } row_t;

    row_t       exp_rows[$];
    logic [3:0] exp_done[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected row stream of one op: addr0 + r*stride, modulo 2^WORD_W.
    task automatic model_push(input logic [1:0] ls, input logic [3:0] rd,
                              input logic [WORD_W-1:0] base, input logic [10:0] imm,
                              input logic [WORD_W-1:0] stride);
        longint immv;
        row_t   e;
        immv = imm[10] ? (longint'(imm) - 2048) : longint'(imm);
        for (int r = 0; r < ROWS; r++) begin
            e.ls   = ls;
            e.mreg = rd;
            e.row  = r;
            e.addr = WORD_W'(longint'(base) + immv + longint'(r) * longint'(stride));
            exp_rows.push_back(e);
        end
        exp_done.push_back(rd);
    endtask

    task automatic issue(input logic [1:0] ls, input logic [3:0] rd,
                         input logic [WORD_W-1:0] base, input logic [10:0] imm,
                         input logic [WORD_W-1:0] stride,
                         input logic exp_ready, input logic exp_accept);
        bus.enable    = 1'b1;
        bus.ls_in     = ls;
        bus.rd_in     = rd;
        bus.rs_in     = 4'd2;
        bus.base_in   = base;
        bus.imm_in    = imm;
        bus.stride_in = stride;
        check("op_ready", bus.op_ready, exp_ready);
        $display("issue ls=%b rd=%0d base=0x%08h imm=0x%03h stride=0x%08h accept=%0b",
                 ls, rd, base, imm, stride, exp_accept);
        if (exp_accept) model_push(ls, rd, base, imm, stride);
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((bus.busy || exp_done.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        check({name, "_busy"}, bus.busy, 0);
        check({name, "_pending_done"}, exp_done.size(), 0);
        check({name, "_pending_rows"}, exp_rows.size(), 0);
    endtask

    // Compare process: every row handshake and done pulse against the scoreboard,
    // and field stability while a request waits for mhit.
    row_t                    mon_e;
    logic                    hold_pend = 1'b0;
    logic [WORD_W-1:0]       hold_addr;
    logic [$clog2(ROWS)-1:0] hold_row;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", bus.req_valid, 1);
                check("hold_addr", bus.req_addr, hold_addr);
                check("hold_row", bus.req_row, hold_row);
            end
            hold_pend = bus.req_valid && !bus.mhit;
            hold_addr = bus.req_addr;
            hold_row  = bus.req_row;
            if (bus.req_valid && bus.mhit) begin
                $display("row  mreg=%0d row=%0d ls=%b addr=0x%08h",
                         bus.req_mreg, bus.req_row, bus.req_ls, bus.req_addr);
                check("row_expected", exp_rows.size() != 0, 1);
                if (exp_rows.size() != 0) begin
                    mon_e = exp_rows.pop_front();
                    check("row_addr", bus.req_addr, mon_e.addr);
                    check("row_idx", bus.req_row, mon_e.row);
                    check("row_ls", bus.req_ls, mon_e.ls);
                    check("row_mreg", bus.req_mreg, mon_e.mreg);
                end
            end
            if (bus.done) begin
                $display("done mreg=%0d", bus.done_mreg);
                check("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) check("done_mreg", bus.done_mreg, exp_done.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    logic [WORD_W-1:0] t1_addr [4];

    initial begin
        bus.enable    = 1'b0;
        bus.ls_in     = 2'b00;
        bus.rd_in     = '0;
        bus.rs_in     = '0;
        bus.base_in   = '0;
        bus.stride_in = '0;
        bus.imm_in    = '0;
        bus.mhit      = 1'b0;
        t1_addr = '{32'h0000_1010, 32'h0000_1050, 32'h0000_1090, 32'h0000_10D0};

        // Reset state
        #12;
        check("rst_op_ready", bus.op_ready, 1);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_req_addr", bus.req_addr, 0);
        check("rst_req_row", bus.req_row, 0);
        check("rst_req_ls", bus.req_ls, 0);
        check("rst_req_mreg", bus.req_mreg, 0);
        check("rst_done_mreg", bus.done_mreg, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Load, mhit held high: four consecutive rows, done at cycle ROWS+2
        bus.mhit = 1'b1;
        issue(LS_LOAD, 4'd5, 32'h1000, 11'h010, 32'h40, 1'b1, 1'b1);
        check("t1_busy_after_accept", bus.busy, 1);
        check("t1_no_bypass", bus.req_valid, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_valid", bus.req_valid, 1);
            check("t1_addr", bus.req_addr, t1_addr[k]);
            check("t1_row", bus.req_row, k);
        end
        tick();
        check("t1_done", bus.done, 1);
        check("t1_done_mreg", bus.done_mreg, 5);
        check("t1_valid_in_done", bus.req_valid, 0);
        tick();
        check("t1_done_pulse", bus.done, 0);
        check("t1_idle", bus.busy, 0);

        // Store with mhit low for three cycles on row 1
        bus.mhit = 1'b0;
        issue(LS_STORE, 4'd3, 32'h2000, 11'h000, 32'h100, 1'b1, 1'b1);
        tick();
        check("t2_row0_addr", bus.req_addr, 32'h2000);
        check("t2_ls", bus.req_ls, LS_STORE);
        check("t2_mreg", bus.req_mreg, 3);
        bus.mhit = 1'b1;
        tick();
        bus.mhit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t2_stall_row", bus.req_row, 1);
            check("t2_stall_addr", bus.req_addr, 32'h2100);
            tick();
        end
        check("t2_still_row1", bus.req_row, 1);
        bus.mhit = 1'b1;
        tick();
        check("t2_row2", bus.req_row, 2);
        check("t2_row2_addr", bus.req_addr, 32'h2200);
        drain("t2");

        // Negative immediate wraps below zero; negative stride walks down
        issue(LS_LOAD, 4'd9, 32'h8, 11'h7F0, 32'hFFFF_FFF0, 1'b1, 1'b1);
        tick();
        check("t3_addr0", bus.req_addr, 32'hFFFF_FFF8);
        tick();
        check("t3_addr1", bus.req_addr, 32'hFFFF_FFE8);
        drain("t3");

        // Sequencer busy, then three back-to-back ops: third refused when full
        bus.mhit = 1'b0;
        issue(LS_LOAD, 4'd10, 32'h5000, 11'h004, 32'h10, 1'b1, 1'b1);
        tick();
        issue(LS_STORE, 4'd11, 32'h6000, 11'h000, 32'h20, 1'b1, 1'b1);
        issue(LS_LOAD, 4'd12, 32'h7000, 11'h7FC, 32'h30, 1'b1, 1'b1);
        issue(LS_STORE, 4'd13, 32'h9000, 11'h000, 32'h40, 1'b0, 1'b0);
        check("t4_full_op_ready", bus.op_ready, 0);
        bus.mhit = 1'b1;
        drain("t4");

        // Illegal encodings: pulse, nothing queued
        issue(2'b11, 4'd4, 32'hA000, 11'h000, 32'h4, 1'b1, 1'b0);
        check("t5_illegal", bus.illegal, 1);
        check("t5_busy", bus.busy, 0);
        check("t5_no_req", bus.req_valid, 0);
        tick();
        check("t5_illegal_pulse", bus.illegal, 0);
        check("t5_busy_after", bus.busy, 0);
        check("t5_no_req_after", bus.req_valid, 0);
        issue(2'b00, 4'd4, 32'hA000, 11'h000, 32'h4, 1'b1, 1'b0);
        check("t5_illegal00", bus.illegal, 1);
        tick();

        // Reset during row 2 with one op queued
        bus.mhit = 1'b0;
        issue(LS_LOAD, 4'd6, 32'h3000, 11'h000, 32'h20, 1'b1, 1'b1);
        issue(LS_STORE, 4'd7, 32'h4000, 11'h000, 32'h8, 1'b1, 1'b1);
        bus.mhit = 1'b1;
        tick();
        tick();
        bus.mhit = 1'b0;
        check("t6_row2", bus.req_row, 2);
        check("t6_row2_addr", bus.req_addr, 32'h3040);
        #1 rst_n = 1'b0;
        #1;
        exp_rows.delete();
        exp_done.delete();
        check("t6_rst_valid", bus.req_valid, 0);
        check("t6_rst_addr", bus.req_addr, 0);
        check("t6_rst_row", bus.req_row, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_op_ready", bus.op_ready, 1);
        check("t6_rst_mreg", bus.req_mreg, 0);
        tick();
        tick();
        rst_n    = 1'b1;
        bus.mhit = 1'b1;
        repeat (6) tick();
        check("t6_busy_after", bus.busy, 0);
        check("t6_valid_after", bus.req_valid, 0);
        check("t6_done_mreg_after", bus.done_mreg, 0);
        check("t6_op_ready_after", bus.op_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
